// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute controller for the 4-bit microcore.
// Drives the instruction-register enable and the program-memory address,
// sequences a 4x4-bit register file with one-cycle read latency, and
// implements a 4-bit ADD with zero and carry flags.
module control_sequencer #(
   parameter int unsigned ACK_TIMEOUT = 8,
   parameter logic [3:0]  RESET_PC    = 4'h0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] ir_mnm,
   input  logic [1:0] ir_wr_addr_mnm,
   input  logic [3:0] ir_rd_addr_wr_data,
   input  logic       ir_ack,
   output logic       ir_ena,
   output logic [3:0] pc_out,
   output logic [1:0] rf_rd_addr,
   input  logic [3:0] rf_rd_data,
   output logic       rf_wr_en,
   output logic [1:0] rf_wr_addr,
   output logic [3:0] rf_wr_data,
   output logic       zero_flag,
   output logic       carry_flag,
   output logic       busy,
   output logic       halted,
   output logic       fault
);

   typedef enum logic [1:0] {
      OP_LDI = 2'b00,
      OP_MOV = 2'b01,
      OP_ADD = 2'b10,
      OP_SYS = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SYS_NOP  = 2'b00,
      SYS_JMP  = 2'b01,
      SYS_JZ   = 2'b10,
      SYS_HALT = 2'b11
   } sys_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_READ1,
      S_READ2,
      S_EXEC,
      S_WRITE,
      S_HALTED,
      S_FAULT
   } state_e;

   localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);

   state_e     state;
   logic [3:0] pc;
   op_e        op;           // opcode of the instruction in flight
   logic [1:0] dst;          // destination register of the instruction in flight
   logic [3:0] op_b;         // source operand captured in READ2
   logic       carry_nxt;    // ADD carry, committed to carry_flag in WRITE
   logic [7:0] timeout_cnt;  // consecutive FETCH cycles without ir_ack

   // Status outputs are pure decodes of the registered state.
   assign pc_out = pc;
   assign halted = (state == S_HALTED);
   assign fault  = (state == S_FAULT);
   assign busy   = !(state inside {S_IDLE, S_HALTED, S_FAULT});

   // Sequencer FSM with registered strobes, register-file addressing and flags.
   // NOTE: every register here is assigned with <= so all updates see the
   // pre-edge values; blocking assignments would create ordering races.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         op          <= OP_LDI;
         dst         <= 2'd0;
         op_b        <= 4'd0;
         carry_nxt   <= 1'b0;
         timeout_cnt <= 8'd0;
         ir_ena      <= 1'b0;
         rf_wr_en    <= 1'b0;
         rf_rd_addr  <= 2'd0;
         rf_wr_addr  <= 2'd0;
         rf_wr_data  <= 4'd0;
         zero_flag   <= 1'b0;
         carry_flag  <= 1'b0;
      end else begin
         // NOTE: strobes default low each cycle and are raised only on entry
         // to the state that owns them, which keeps them exactly one state long.
         ir_ena   <= 1'b0;
         rf_wr_en <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_FETCH;
                  ir_ena      <= 1'b1;
                  timeout_cnt <= 8'd0;
               end
            end

            S_FETCH: begin
               if (ir_ack) begin
                  state <= S_DECODE;
               end else if (timeout_cnt + 8'd1 == ACK_LIMIT) begin
                  state <= S_FAULT;
               end else begin
                  timeout_cnt <= timeout_cnt + 8'd1;
                  ir_ena      <= 1'b1;
               end
            end

            S_DECODE: begin
               op  <= op_e'(ir_mnm);
               dst <= ir_wr_addr_mnm;
               case (op_e'(ir_mnm))
                  OP_LDI: begin
                     rf_wr_addr <= ir_wr_addr_mnm;
                     rf_wr_data <= ir_rd_addr_wr_data;
                     rf_wr_en   <= 1'b1;
                     state      <= S_WRITE;
                  end
                  OP_MOV, OP_ADD: begin
                     rf_rd_addr <= ir_rd_addr_wr_data[1:0];
                     state      <= S_READ1;
                  end
                  default: begin
                     case (sys_e'(ir_wr_addr_mnm))
                        SYS_HALT: state <= S_HALTED;
                        default: begin
                           if (sys_e'(ir_wr_addr_mnm) == SYS_JMP)
                              pc <= ir_rd_addr_wr_data;
                           else if (sys_e'(ir_wr_addr_mnm) == SYS_JZ && zero_flag)
                              pc <= ir_rd_addr_wr_data;
                           else
                              pc <= pc + 4'd1;
                           state       <= S_FETCH;
                           ir_ena      <= 1'b1;
                           timeout_cnt <= 8'd0;
                        end
                     endcase
                  end
               endcase
            end

            // Source address is on the bus; for ADD, queue the destination
            // read so its data arrives in EXEC.
            S_READ1: begin
               if (op == OP_ADD)
                  rf_rd_addr <= dst;
               state <= S_READ2;
            end

            S_READ2: begin
               op_b <= rf_rd_data;
               if (op == OP_MOV) begin
                  rf_wr_addr <= dst;
                  rf_wr_data <= rf_rd_data;
                  rf_wr_en   <= 1'b1;
                  state      <= S_WRITE;
               end else begin
                  state <= S_EXEC;
               end
            end

            S_EXEC: begin
               {carry_nxt, rf_wr_data} <= {1'b0, rf_rd_data} + {1'b0, op_b};
               rf_wr_addr <= dst;
               rf_wr_en   <= 1'b1;
               state      <= S_WRITE;
            end

            S_WRITE: begin
               zero_flag <= (rf_wr_data == 4'd0);
               if (op == OP_ADD)
                  carry_flag <= carry_nxt;
               pc          <= pc + 4'd1;
               state       <= S_FETCH;
               ir_ena      <= 1'b1;
               timeout_cnt <= 8'd0;
            end

            S_HALTED: state <= S_HALTED;
            S_FAULT:  state <= S_FAULT;
            default:  state <= S_FAULT;
         endcase
      end
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/execute controller for the 4-bit microcore. It sits directly downstream of the instruction register and consumes its mnm, wr_addr_mnm and rd_addr_wr_data fields and its ack.
- It drives the instruction-register enable and the program-memory address (pc_out), and sequences the 4x4-bit register file.
- It implements a 4-bit ADD datapath with zero and carry flags.
- Instruction word is {mnm[1:0], wr_addr_mnm[1:0], rd_addr_wr_data[3:0]}.

Parameters:
- ACK_TIMEOUT, 8, consecutive FETCH cycles without ir_ack before entering FAULT (valid range 1..255).
- RESET_PC, 4'h0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin execution from IDLE; ignored in all other states
- ir_mnm  input  2  instruction-register mnm field
- ir_wr_addr_mnm  input  2  destination register, or sub-opcode when mnm=11
- ir_rd_addr_wr_data  input  4  immediate/jump target; bits [1:0] are the source register
- ir_ack  input  1  instruction-register load acknowledge
- ir_ena  output  1  instruction-register enable
- pc_out  output  4  program-memory address
- rf_rd_addr  output  2  register-file read address; data returns one cycle later
- rf_rd_data  input  4  register-file read data
- rf_wr_en  output  1  register-file write strobe, one cycle
- rf_wr_addr  output  2  register-file write address
- rf_wr_data  output  4  register-file write data
- zero_flag  output  1  last written result == 0
- carry_flag  output  1  carry out of last ADD
- busy  output  1  state is neither IDLE, HALTED nor FAULT
- halted  output  1  state is HALTED
- fault  output  1  state is FAULT

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, pc=RESET_PC.
  - zero_flag=0, carry_flag=0.
  - All strobes (ir_ena, rf_wr_en) = 0; rf addresses and rf_wr_data = 0; timeout counter = 0.
  - Reset takes priority in any state, including mid-instruction; an in-flight write is dropped.
- Output timing:
  - All outputs decode from registered state, pc, operand and flag registers. No combinational path from inputs to outputs.
- ISA:
  - mnm=00 LDI: R[dst] <= imm.
  - mnm=01 MOV: R[dst] <= R[src].
  - mnm=10 ADD: R[dst] <= R[dst] + R[src].
  - mnm=11, wr_addr_mnm selects: 00 NOP; 01 JMP, pc <= imm; 10 JZ, pc <= imm if zero_flag else pc+1; 11 HALT.
- States:
  - IDLE: start=1 -> FETCH.
  - FETCH: ir_ena=1, pc_out=pc.
    - ir_ack=1 -> DECODE. ir_ena drops the next cycle.
    - Otherwise the counter increments. On reaching ACK_TIMEOUT -> FAULT.
    - The counter clears on every FETCH entry.
  - DECODE: latch op, dst, imm/src from the IR fields.
    - LDI -> WRITE with wdata=imm.
    - MOV/ADD -> READ1.
    - NOP: pc+1, -> FETCH.
    - JMP/JZ: update pc as defined, -> FETCH.
    - HALT -> HALTED; pc is not incremented.
  - READ1: rf_rd_addr=src -> READ2.
  - READ2: capture opB=rf_rd_data.
    - MOV: wdata=opB, -> WRITE.
    - ADD: rf_rd_addr=dst, -> EXEC.
  - EXEC: capture opA=rf_rd_data; {carry, sum} = opA + opB as a 5-bit sum; wdata=sum[3:0]; -> WRITE.
  - WRITE: rf_wr_en=1 for exactly one cycle, with rf_wr_addr=dst and rf_wr_data=wdata.
    - zero_flag <= (wdata==0).
    - carry_flag updated only by ADD; LDI and MOV preserve it.
    - pc+1, then -> FETCH.
  - HALTED and FAULT: terminal until rst. start is ignored. No strobes are issued.
- Arithmetic:
  - pc increments modulo 16 (15 -> 0).
  - ADD wraps modulo 16, with the carry captured in carry_flag.
  - NOP, JMP and JZ do not alter the flags.
- Latency (cycles from ir_ack to the next FETCH entry):
  - NOP/JMP/JZ: 1.
  - LDI: 2.
  - MOV: 4.
  - ADD: 5.
- Boundary conditions:
  - dst==src is legal for both MOV and ADD (ADD doubles the register).
  - ir_ack outside FETCH is ignored.
  - start while busy is ignored.

Test Plan:
- LDI: reset, start, program word 0x15 (LDI R1,5) -> ir_ena held until ack; 2 cycles later rf_wr_en=1, addr=1, data=5; zero_flag=0; pc_out=1 at next FETCH.
- ADD with carry: R2=9, R3=8, word 0xA3 (ADD R2,R3) -> reads addr 3 then 2; write addr=2, data=1; carry_flag=1, zero_flag=0; exactly 5 cycles from ack to FETCH.
- JZ taken and not taken: after LDI R0,0 (zero_flag=1), word 0xE9 (JZ 9) -> pc_out=9. After a nonzero write, same word -> pc+1. Flags unchanged in both cases.
- Ack timeout: ir_ack held 0 -> after 8 FETCH cycles fault=1, busy=0, ir_ena=0; start ignored; rst -> IDLE with pc=0.
- Halt and wrap: pc=15 executing NOP -> pc_out=0. Then HALT (0xF0) -> halted=1 and pc held; further start and ir_ack produce no strobes.
- Reset mid-ADD: assert rst during EXEC -> next cycle state=IDLE, rf_wr_en never pulses, flags=0, pc=RESET_PC.
